controle_multiciclo: RTL and testbench
======================================

# controle_multiciclo

Multicycle MIPS control unit. A Moore FSM decodes the 6-bit opcode from the instruction register. It drives every select line of the datapath's 2:1 and 4:1 multiplexers (IorD, ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource), plus all register and memory write enables. It sits directly upstream of the multiplexers and holds the datapath in a memory wait state via a ready handshake.

## Interface
Parameters:
- `STATE_W`, default 4: state register width; must be ≥4.

Ports:
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: instr[31:26] from the instruction register.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if the ALU zero flag is set (beq).
- `iord` out 1: memory address mux select; 0=PC, 1=ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: instruction register load.
- `mem_to_reg` out 1: writeback mux select; 0=ALUOut, 1=MDR.
- `reg_dst` out 1: destination mux select; 0=rt, 1=rd.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A mux select; 0=PC, 1=A.
- `alu_src_b` out 2: ALU B mux select; 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2.
- `alu_op` out 2: 00=add, 01=sub, 10=funct-decoded.
- `pc_source` out 2: PC mux select; 00=ALU result, 01=ALUOut, 10=jump target.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out STATE_W: current state, for debug.

## Operation
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Outputs are pure functions of state, except write enables that are gated by `mem_ready` as noted below. Every output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while !mem_ready; otherwise go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX (only with the macro defined)
  - anything else → FETCH, with illegal_op=1 in DECODE.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Wait on mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEMWR: mem_write=1, iord=1. Wait on mem_ready, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
- JUMP: pc_write=1, pc_source=10. Go to FETCH.
- `opcode` is sampled only in DECODE and MEMADR. It is a don't-care in every other state.
- An unreachable state encoding goes to FETCH on the next clock.

## Timing
- Reset: state=FETCH asynchronously. While rst=1, all outputs are forced to 0, including mem_read. After rst falls, FETCH outputs appear combinationally in the same cycle.
- Cycles per instruction with mem_ready held at 1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Write enables during a wait: ir_write, pc_write, reg_write and mem_write are never asserted for more than one committed cycle per state. While FETCH waits, ir_write and pc_write stay 0.
- rst asserted mid-instruction: the FSM abandons the instruction, goes to FETCH immediately, and all outputs go to 0. No partial writeback follows.
- State transitions occur only on the rising clk edge.

## Configuration
- `CTRL_ADDI_EN` defined:
  - opcode 001000 goes DECODE→ADDIEX→ADDIWB→FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
- `CTRL_ADDI_EN` undefined:
  - opcode 001000 is illegal: illegal_op pulses in DECODE and the FSM returns to FETCH.
  - States 10 and 11 are unreachable.

## Test plan
- Reset: rst=1 mid-EXEC → state=0 and all outputs 0 within the same cycle. Release rst → FETCH with mem_read=1, alu_src_b=01, pc_write=1.
- lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0. MEMWB shows reg_write=1, mem_to_reg=1, reg_dst=0.
- sw (opcode 101011) with mem_ready low for 2 cycles in MEMWR → MEMWR lasts 3 cycles with mem_write=1, iord=1. No reg_write at any point.
- R-type (000000), beq (000100), j (000010) back-to-back → 4, 3 and 3 cycles. BRANCH has pc_write_cond=1, pc_source=01. JUMP has pc_write=1, pc_source=10.
- FETCH with mem_ready=0 for 3 cycles → ir_write=pc_write=0 for those cycles. Both are 1 only on the ready cycle, then DECODE follows.
- opcode 001000:
  - Macro defined: states 0,1,10,11,0, with ADDIWB reg_write=1, reg_dst=0.
  - Macro undefined: illegal_op=1 for one cycle in DECODE, then FETCH.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM driving datapath mux selects and write enables.
// Optional addi support is compiled in when CTRL_ADDI_EN is defined.
module controle_multiciclo #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXEC   = STATE_W'(6),
        ALUWB  = STATE_W'(7),
        BRANCH = STATE_W'(8),
        JUMP   = STATE_W'(9),
        ADDIEX = STATE_W'(10),
        ADDIWB = STATE_W'(11)
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // State register, forced to FETCH asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign state = state_r;

    // Next-state and Moore output decode; rst overrides every output to 0.
    always_comb begin
        state_next_s  = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        if (rst) begin
            state_next_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    // IR and PC commit only on the cycle memory delivers the word.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) begin
                        state_next_s = DECODE;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE: state_next_s = EXEC;
                        OP_LW:    state_next_s = MEMADR;
                        OP_SW:    state_next_s = MEMADR;
                        OP_BEQ:   state_next_s = BRANCH;
                        OP_J:     state_next_s = JUMP;
`ifdef CTRL_ADDI_EN
                        OP_ADDI:  state_next_s = ADDIEX;
`endif
                        default: begin
                            state_next_s = FETCH;
                            illegal_op   = 1'b1;
                        end
                    endcase
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (opcode == OP_SW) begin
                        state_next_s = MEMWR;
                    end else begin
                        state_next_s = MEMRD;
                    end
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        state_next_s = MEMWB;
                    end else begin
                        state_next_s = MEMRD;
                    end
                end
                MEMWB: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = 1'b1;
                    state_next_s = FETCH;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        state_next_s = FETCH;
                    end else begin
                        state_next_s = MEMWR;
                    end
                end
                EXEC: begin
                    alu_src_a    = 1'b1;
                    alu_op       = 2'b10;
                    state_next_s = ALUWB;
                end
                ALUWB: begin
                    reg_write    = 1'b1;
                    reg_dst      = 1'b1;
                    state_next_s = FETCH;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    state_next_s  = FETCH;
                end
                JUMP: begin
                    pc_write     = 1'b1;
                    pc_source    = 2'b10;
                    state_next_s = FETCH;
                end
`ifdef CTRL_ADDI_EN
                ADDIEX: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'b10;
                    state_next_s = ADDIWB;
                end
                ADDIWB: begin
                    reg_write    = 1'b1;
                    state_next_s = FETCH;
                end
`endif
                default: begin
                    state_next_s = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized scoreboard bench for controle_multiciclo: instructions expand into expected
// per-cycle phases (state + control word) queued for a negedge monitor.
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    controle_multiciclo #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_JUMP = 9,
                   S_ADDIEX = 10, S_ADDIWB = 11;

`ifdef CTRL_ADDI_EN
    localparam bit ADDI_ON = 1'b1;
`else
    localparam bit ADDI_ON = 1'b0;
`endif

    logic [20:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Control word a phase must show, listed directly from the per-state output table.
    function automatic logic [16:0] exp_ctrl(int st, bit rdy, bit ill);
        logic pcw = 1'b0, pcwc = 1'b0, ad = 1'b0, mr = 1'b0, mw = 1'b0, irw = 1'b0;
        logic m2r = 1'b0, rd = 1'b0, rw = 1'b0, asa = 1'b0, ilg = 1'b0;
        logic [1:0] asb = 2'b00, aop = 2'b00, pcs = 2'b00;
        case (st)
            S_FETCH:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: begin asb = 2'b11; ilg = ill; end
            S_MEMADR: begin asa = 1'b1; asb = 2'b10; end
            S_MEMRD:  begin mr = 1'b1; ad = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWR:  begin mw = 1'b1; ad = 1'b1; end
            S_EXEC:   begin asa = 1'b1; aop = 2'b10; end
            S_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
            S_BRANCH: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            S_JUMP:   begin pcw = 1'b1; pcs = 2'b10; end
            S_ADDIEX: begin asa = 1'b1; asb = 2'b10; end
            S_ADDIWB: begin rw = 1'b1; end
            default:  begin end
        endcase
        return {pcw, pcwc, ad, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ilg};
    endfunction

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        logic [20:0] e;
        logic [20:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                 illegal_op};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl t=%0t state got %0d exp %0d, ctrl got %h exp %h",
                         $time, a[20:17], e[20:17], a[16:0], e[16:0]);
            end
        end
    end

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    // One cycle: drive inputs just after the edge and queue what the DUT must show.
    task automatic step(int st, bit rdy, logic [5:0] op, bit ill, bit r);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        opcode    = op;
        if (r) exp_q.push_back(21'd0);
        else   exp_q.push_back({4'(st), exp_ctrl(st, rdy, ill)});
    endtask

    task automatic wait_phase(int st, int waits);
        for (int i = 0; i < waits; i++) step(st, 1'b0, rnd_op(), 1'b0, 1'b0);
        step(st, 1'b1, rnd_op(), 1'b0, 1'b0);
    endtask

    // Expand one instruction into its phase sequence with the requested memory waits.
    task automatic run_instr(logic [5:0] op, int fw, int mw);
        bit legal;
        legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
                (op == OP_J) || (ADDI_ON && op == OP_ADDI);
        wait_phase(S_FETCH, fw);
        step(S_DECODE, 1'($urandom), op, !legal, 1'b0);
        if (op == OP_LW || op == OP_SW) begin
            step(S_MEMADR, 1'($urandom), op, 1'b0, 1'b0);
            if (op == OP_LW) begin
                wait_phase(S_MEMRD, mw);
                step(S_MEMWB, 1'($urandom), rnd_op(), 1'b0, 1'b0);
            end else begin
                wait_phase(S_MEMWR, mw);
            end
        end else if (op == OP_R) begin
            step(S_EXEC, 1'($urandom), rnd_op(), 1'b0, 1'b0);
            step(S_ALUWB, 1'($urandom), rnd_op(), 1'b0, 1'b0);
        end else if (op == OP_BEQ) begin
            step(S_BRANCH, 1'($urandom), rnd_op(), 1'b0, 1'b0);
        end else if (op == OP_J) begin
            step(S_JUMP, 1'($urandom), rnd_op(), 1'b0, 1'b0);
        end else if (legal) begin
            step(S_ADDIEX, 1'($urandom), rnd_op(), 1'b0, 1'b0);
            step(S_ADDIWB, 1'($urandom), rnd_op(), 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [5:0] pick[7];
        pick = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b111111};

        step(S_FETCH, 1'b1, 6'd0, 1'b0, 1'b1);
        step(S_FETCH, 1'b1, 6'd0, 1'b0, 1'b1);

        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 2);
        run_instr(OP_R, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_R, 3, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(6'b111111, 1, 0);
        run_instr(OP_LW, 2, 3);

        // Reset asserted during EXEC, held a cycle, then released straight into FETCH.
        wait_phase(S_FETCH, 0);
        step(S_DECODE, 1'b1, OP_R, 1'b0, 1'b0);
        step(S_EXEC, 1'b1, 6'd0, 1'b0, 1'b1);
        step(S_EXEC, 1'b1, 6'd0, 1'b0, 1'b1);
        step(S_FETCH, 1'b1, rnd_op(), 1'b0, 1'b0);
        step(S_DECODE, 1'b1, OP_J, 1'b0, 1'b0);
        step(S_JUMP, 1'b1, rnd_op(), 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            op = pick[$urandom_range(0, 6)];
            if (op == 6'b111111) op = rnd_op();
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
